// File: rtl/buffer_controller.sv
`default_nettype none
// ============================================================================
// Module   : buffer_controller
// Brief    : Pointer/occupancy/mode sequencer for the 64-byte endpoint buffer
//            shared by the AHB-lite slave side and the USB RX/TX packet side.
// Revision : 1.0 - initial release
// ============================================================================
module buffer_controller #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          d_mode,
  input  logic          clear,
  input  logic          store_tx_data,
  input  logic [7:0]    tx_data,
  input  logic          get_rx_data,
  input  logic          store_rx_packet_data,
  input  logic [7:0]    rx_packet_data,
  input  logic          get_tx_packet_data,
  input  logic [7:0]    ram_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [7:0]    ram_wdata,
  output logic [AW-1:0] ram_raddr,
  output logic [7:0]    rx_data,
  output logic [7:0]    tx_packet_data,
  output logic [AW:0]   buffer_occupancy,
  output logic          empty,
  output logic          full,
  output logic          mode,
  output logic          busy,
  output logic [2:0]    buf_err
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_TX    = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   occupancy;
  logic [2:0]    err;

  logic          wr_stb;
  logic [7:0]    wr_byte;
  logic          rd_stb;
  logic          wrong_side;
  logic          wr_ok;
  logic          wr_ovf;
  logic          rd_ok;
  logic          rd_unf;

  // Strobe steering, acceptance decisions, RAM/data outputs and next state
  always_comb begin
    wr_stb         = 1'b0;
    wr_byte        = 8'h00;
    rd_stb         = 1'b0;
    wrong_side     = 1'b0;
    next_state     = state;
    rx_data        = 8'h00;
    tx_packet_data = 8'h00;

    // A clear cycle and the flush cycle both ignore every strobe silently.
    if (!clear && state == ST_RX) begin
      wr_stb     = store_rx_packet_data;
      wr_byte    = rx_packet_data;
      rd_stb     = get_rx_data;
      wrong_side = store_tx_data | get_tx_packet_data;
    end else if (!clear && state == ST_TX) begin
      wr_stb     = store_tx_data;
      wr_byte    = tx_data;
      rd_stb     = get_tx_packet_data;
      wrong_side = store_rx_packet_data | get_rx_data;
    end

    // Full/empty judged on the occupancy before this cycle: a read in the
    // same cycle does not make room for a write.
    wr_ok  = wr_stb && (occupancy != FULL_CNT);
    wr_ovf = wr_stb && (occupancy == FULL_CNT);
    rd_ok  = rd_stb && (occupancy != '0);
    rd_unf = rd_stb && (occupancy == '0);

    if (rd_ok && state == ST_RX) rx_data        = ram_rdata;
    if (rd_ok && state == ST_TX) tx_packet_data = ram_rdata;

    case (state)
      ST_RX:    if (d_mode && occupancy == '0)  next_state = ST_TX;
      ST_TX:    if (!d_mode && occupancy == '0) next_state = ST_RX;
      ST_FLUSH: next_state = d_mode ? ST_TX : ST_RX;
      default:  next_state = ST_RX;
    endcase
    if (clear) next_state = ST_FLUSH;
  end

  assign ram_wen          = wr_ok;
  assign ram_waddr        = wptr;
  assign ram_wdata        = wr_byte;
  assign ram_raddr        = rptr;
  assign buffer_occupancy = occupancy;
  assign empty            = (occupancy == '0);
  assign full             = (occupancy == FULL_CNT);
  assign mode             = (state == ST_TX);
  assign busy             = (state == ST_FLUSH);
  assign buf_err          = err;

  // State, pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_RX;
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      err       <= 3'b000;
    end else begin
      state <= next_state;
      if (state == ST_FLUSH) begin
        wptr      <= '0;
        rptr      <= '0;
        occupancy <= '0;
        err       <= 3'b000;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        if (rd_ok) rptr <= rptr + 1'b1;
        case ({wr_ok, rd_ok})
          2'b10:   occupancy <= occupancy + 1'b1;
          2'b01:   occupancy <= occupancy - 1'b1;
          default: occupancy <= occupancy;
        endcase
        err <= err | {wrong_side, rd_unf, wr_ovf};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buffer_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_controller
// Brief    : Scoreboard bench for buffer_controller with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_controller;

  localparam logic [7:0] C_CLR = 8'h01;
  localparam logic [7:0] C_STX = 8'h02;
  localparam logic [7:0] C_GRX = 8'h04;
  localparam logic [7:0] C_SRX = 8'h08;
  localparam logic [7:0] C_GTX = 8'h10;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_mode = 1'b0, clear = 1'b0;
  logic       store_tx_data = 1'b0, get_rx_data = 1'b0;
  logic       store_rx_packet_data = 1'b0, get_tx_packet_data = 1'b0;
  logic [7:0] tx_data = 8'h00, rx_packet_data = 8'h00;
  logic [7:0] ram_rdata;
  logic       ram_wen;
  logic [5:0] ram_waddr, ram_raddr;
  logic [7:0] ram_wdata, rx_data, tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       empty, full, mode, busy;
  logic [2:0] buf_err;

  buffer_controller #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .n_rst(n_rst), .d_mode(d_mode), .clear(clear),
    .store_tx_data(store_tx_data), .tx_data(tx_data),
    .get_rx_data(get_rx_data),
    .store_rx_packet_data(store_rx_packet_data), .rx_packet_data(rx_packet_data),
    .get_tx_packet_data(get_tx_packet_data), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .rx_data(rx_data), .tx_packet_data(tx_packet_data),
    .buffer_occupancy(buffer_occupancy), .empty(empty), .full(full),
    .mode(mode), .busy(busy), .buf_err(buf_err)
  );

  always #5 clk = ~clk;

  // Byte RAM: synchronous write, combinational read
  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  typedef struct {
    logic [6:0] occ;
    logic       empty, full, mode, busy;
    logic [2:0] err;
    logic       wen;
    logic [5:0] waddr;
    logic [7:0] wdata, rx, tx;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("occupancy", 32'(buffer_occupancy), 32'(e.occ));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("full", 32'(full), 32'(e.full));
      chk("mode", 32'(mode), 32'(e.mode));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("buf_err", 32'(buf_err), 32'(e.err));
      chk("ram_wen", 32'(ram_wen), 32'(e.wen));
      if (e.wen) begin
        chk("ram_waddr", 32'(ram_waddr), 32'(e.waddr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
      end
      chk("rx_data", 32'(rx_data), 32'(e.rx));
      chk("tx_packet_data", 32'(tx_packet_data), 32'(e.tx));
    end
  end

  // Reference model: the buffer is a byte queue; state 0 = RX, 1 = TX, 2 = FLUSH
  logic [7:0] mq[$];
  int         mst  = 0;
  logic [2:0] merr = 3'b000;
  int         wcnt = 0;

  task automatic model_reset();
    mq.delete();
    mst  = 0;
    merr = 3'b000;
    wcnt = 0;
  endtask

  // One clock of stimulus; expectation pushed, model advanced
  task automatic step(input logic [7:0] cmd, input logic [7:0] wb, input logic dm);
    exp_t e;
    int   occ, nst;
    bit   act, prod, cons, wrong, wacc, racc;
    logic [7:0] rdv;
    @(posedge clk); #1;
    d_mode = dm; clear = cmd[0]; store_tx_data = cmd[1]; tx_data = wb;
    get_rx_data = cmd[2]; store_rx_packet_data = cmd[3]; rx_packet_data = wb;
    get_tx_packet_data = cmd[4];

    occ   = mq.size();
    act   = !cmd[0] && mst != 2;
    prod  = act && ((mst == 0) ? cmd[3] : cmd[1]);
    cons  = act && ((mst == 0) ? cmd[2] : cmd[4]);
    wrong = act && ((mst == 0) ? (cmd[1] | cmd[4]) : (cmd[3] | cmd[2]));
    wacc  = prod && occ < 64;
    racc  = cons && occ > 0;
    rdv   = racc ? mq[0] : 8'h00;

    e.occ = occ[6:0]; e.empty = (occ == 0); e.full = (occ == 64);
    e.mode = (mst == 1); e.busy = (mst == 2); e.err = merr;
    e.wen = wacc; e.waddr = wcnt[5:0]; e.wdata = wb;
    e.rx = (mst == 0) ? rdv : 8'h00;
    e.tx = (mst == 1) ? rdv : 8'h00;
    exp_q.push_back(e);

    if (cmd[0])        nst = 2;
    else if (mst == 2) nst = int'(dm);
    else if (occ == 0) nst = int'(dm);
    else               nst = mst;

    if (mst == 2) begin
      mq.delete(); wcnt = 0; merr = 3'b000;
    end else begin
      merr = merr | {wrong, cons && occ == 0, prod && occ == 64};
      if (racc) void'(mq.pop_front());
      if (wacc) begin
        mq.push_back(wb);
        wcnt = (wcnt + 1) % 64;
      end
    end
    mst = nst;
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge
  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    n_rst = 1'b0;
    d_mode = 0; clear = 0; store_tx_data = 0; get_rx_data = 0;
    store_rx_packet_data = 0; get_tx_packet_data = 0;
    model_reset();
    e.occ = 7'd0; e.empty = 1; e.full = 0; e.mode = 0; e.busy = 0; e.err = 3'b000;
    e.wen = 0; e.waddr = 6'd0; e.wdata = 8'h00; e.rx = 8'h00; e.tx = 8'h00;
    exp_q.push_back(e);
    @(negedge clk); #1;
    n_rst = 1'b1;
  endtask

  initial begin
    int phase;
    logic [7:0] cmd;
    logic dm;
    do_reset();

    // RX fill and drain
    step(C_SRX, 8'hA1, 0); step(C_SRX, 8'hB2, 0); step(C_SRX, 8'hC3, 0);
    for (int i = 0; i < 3; i++) step(C_GRX, 8'h00, 0);

    // Switch to TX, fill to full across the pointer wrap, then overflow
    step(8'h00, 8'h00, 1); step(8'h00, 8'h00, 1);
    for (int i = 0; i < 64; i++) step(C_STX, 8'(i * 3 + 1), 1);
    step(C_STX, 8'hEE, 1);

    // Drain to 5, simultaneous read and write, drain out
    for (int i = 0; i < 59; i++) step(C_GTX, 8'h00, 1);
    step(C_STX | C_GTX, 8'h77, 1);
    for (int i = 0; i < 5; i++) step(C_GTX, 8'h00, 1);

    // Back to RX: underflow, then a wrong-side write
    step(8'h00, 8'h00, 0); step(8'h00, 8'h00, 0);
    step(C_GRX, 8'h00, 0);
    step(C_STX, 8'h55, 0);

    // Flush, then build occupancy 10 with buf_err = 011
    step(C_CLR, 8'h00, 0); step(8'h00, 8'h00, 0);
    for (int i = 0; i < 65; i++) step(C_SRX, 8'(i ^ 8'h3C), 0);
    for (int i = 0; i < 65; i++) step(C_GRX, 8'h00, 0);
    for (int i = 0; i < 10; i++) step(C_SRX, 8'(8'h80 + i), 0);
    step(C_CLR | C_SRX, 8'h99, 1);
    step(8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 1);

    // Deferred mode switch: RX holding two bytes while d_mode requests TX
    step(C_CLR, 8'h00, 0); step(8'h00, 8'h00, 0);
    step(C_SRX, 8'h11, 0); step(C_SRX, 8'h22, 0);
    step(8'h00, 8'h00, 1);
    step(C_GRX, 8'h00, 1); step(C_GRX, 8'h00, 1);
    step(8'h00, 8'h00, 1); step(8'h00, 8'h00, 1);

    // Reset in the middle of TX traffic
    step(C_STX, 8'h42, 1); step(C_STX, 8'h43, 1);
    do_reset();

    // Randomized traffic with phases biased toward filling or draining
    dm = 0;
    for (int n = 0; n < 3000; n++) begin
      phase = (n / 200) % 2;
      if ($urandom_range(49) == 0) dm = ~dm;
      cmd = 8'h00;
      if ($urandom_range(99) == 0) cmd |= C_CLR;
      if ($urandom_range(99) < (phase ? 70 : 35)) cmd |= (dm ? C_STX : C_SRX);
      if ($urandom_range(99) < (phase ? 30 : 65)) cmd |= (dm ? C_GTX : C_GRX);
      if ($urandom_range(99) < 3) cmd |= (dm ? C_SRX : C_STX);
      if ($urandom_range(99) < 3) cmd |= (dm ? C_GRX : C_GTX);
      step(cmd, 8'($urandom), dm);
    end
    step(8'h00, 8'h00, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
